// File: rtl/mux_scan_sequencer_if.sv
// Channel-mux scan bus: select/sample lines to the mux plus the packed-word stream.
// Latency: pure wiring, no state.
// Backpressure: data_ready from the consumer stalls the producer behind the master modport.
interface mux_scan_sequencer_if #(
  parameter int SEL_W  = 6,
  parameter int WORD_W = 8
);
  logic              start;
  logic              cont;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_out;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;

  // Sequencer side: drives the mux select and the word stream.
  modport master (
    input  start, cont, mux_out, data_ready,
    output mux_sel, data_out, data_valid, busy, done
  );

  // Environment side: mux plus word consumer plus control.
  modport slave (
    output start, cont, mux_out, data_ready,
    input  mux_sel, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans NUM_CH mux channels in order, packs sampled bits LSB-first into WORD_W-bit words.
// Latency: 1 clk/channel (2 with MUX_SETTLE_EN); word j valid after edge WORD_W*(j+1) from start.
// Backpressure: a full output slot parks the finished word in pending and freezes the scan.
module mux_scan_sequencer #(
  parameter int NUM_CH = 64,
  parameter int SEL_W  = 6,
  parameter int WORD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_scan_sequencer_if.master bus
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_STALL  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

`ifdef MUX_SETTLE_EN
  // Every new select value gets one settle cycle before it is sampled.
  localparam state_e NEXT_CH_ST = ST_SETTLE;
`else
  localparam state_e NEXT_CH_ST = ST_SAMPLE;
`endif

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  mux_sel_q, mux_sel_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [WORD_W-1:0] pending_q, pending_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] word;
  logic              slot_free;
  logic              advance;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mux_sel_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      pending_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mux_sel_q    <= mux_sel_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      pending_q    <= pending_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state: sample, pack, hand off or park the word, then step the select.
  always_comb begin
    state_d      = state_q;
    mux_sel_d    = mux_sel_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    pending_d    = pending_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    done_d       = 1'b0;
    advance      = 1'b0;

    // The last bit of a word goes straight from the mux, never through shift.
    word      = {bus.mux_out, shift_q};
    slot_free = !data_valid_q || bus.data_ready;

    // An accepted word retires; a word loaded below on the same edge overrides this.
    if (data_valid_q && bus.data_ready) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        mux_sel_d = '0;
        bit_idx_d = '0;
        if (bus.start) begin
          state_d = NEXT_CH_ST;
        end
      end
`ifdef MUX_SETTLE_EN
      ST_SETTLE: begin
        state_d = ST_SAMPLE;
      end
`endif
      ST_SAMPLE: begin
        if (bit_idx_q != LAST_BIT) begin
          shift_d[bit_idx_q] = bus.mux_out;
          bit_idx_d          = bit_idx_q + BIT_W'(1);
          mux_sel_d          = mux_sel_q + SEL_W'(1);
          state_d            = NEXT_CH_ST;
        end else if (slot_free) begin
          data_out_d   = word;
          data_valid_d = 1'b1;
          advance      = 1'b1;
        end else begin
          // Slot still occupied: keep the word and hold the select where it is.
          pending_d = word;
          state_d   = ST_STALL;
        end
      end
      ST_STALL: begin
        if (slot_free) begin
          data_out_d   = pending_q;
          data_valid_d = 1'b1;
          advance      = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Word boundary reached and handed off: move to the next channel or end the frame.
    if (advance) begin
      bit_idx_d = '0;
      if (mux_sel_q == LAST_CH) begin
        mux_sel_d = '0;
        if (bus.cont) begin
          state_d = NEXT_CH_ST;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        mux_sel_d = mux_sel_q + SEL_W'(1);
        state_d   = NEXT_CH_ST;
      end
    end
  end

  // Outputs: all registered except busy, which decodes the state register.
  always_comb begin
    bus.mux_sel    = mux_sel_q;
    bus.data_out   = data_out_q;
    bus.data_valid = data_valid_q;
    bus.done       = done_q;
    bus.busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
`timescale 1ns/1ps
module tb_mux_scan_sequencer;

`ifdef MUX_SETTLE_EN
  localparam int CPC = 2;
`else
  localparam int CPC = 1;
`endif
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux_scan_sequencer_if #(.SEL_W(6), .WORD_W(8)) bus ();

  mux_scan_sequencer #(.NUM_CH(64), .SEL_W(6), .WORD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational 64:1 mux model.
  logic [63:0] mux_in;
  assign mux_in = 64'hF0E1_D2C3_B4A5_9687;
  assign bus.mux_out = mux_in[bus.mux_sel];

  logic [7:0] exp_words [8];
  logic [7:0] got_q [$];

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int vi;
  logic early_done;

  typedef struct {
    int         e;
    logic       rdy;
    logic       vld;
    logic [7:0] dat;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t vec [NV];

  // Record every word the consumer accepts at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.data_valid === 1'b1 && bus.data_ready === 1'b1)
      got_q.push_back(bus.data_out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    bus.start      = 1'b0;
    bus.cont       = 1'b0;
    bus.data_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    got_q.delete();
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    edge_n = 0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic check_words(input string name, input int nframes);
    check({name, " word count"}, got_q.size(), 8 * nframes);
    for (int i = 0; i < got_q.size() && i < 8 * nframes; i++)
      check({name, " word"}, got_q[i], exp_words[i % 8]);
  endtask

  function automatic vec_t mk(input int e, input logic vld, input logic [7:0] dat,
                              input logic busy, input logic done);
    vec_t v;
    v.e = e; v.rdy = 1'b1; v.vld = vld; v.dat = dat; v.busy = busy; v.done = done;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_words = '{8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    vec[0] = mk(0,            1'b0, 8'h00, 1'b1, 1'b0);
    vec[1] = mk(CPC,          1'b0, 8'h00, 1'b1, 1'b0);
    vec[2] = mk(7 * CPC,      1'b0, 8'h00, 1'b1, 1'b0);
    vec[3] = mk(8 * CPC,      1'b1, 8'h87, 1'b1, 1'b0);
    vec[4] = mk(8 * CPC + 1,  1'b0, 8'h00, 1'b1, 1'b0);
    vec[5] = mk(16 * CPC,     1'b1, 8'h96, 1'b1, 1'b0);
    vec[6] = mk(40 * CPC,     1'b1, 8'hC3, 1'b1, 1'b0);
    vec[7] = mk(63 * CPC,     1'b0, 8'h00, 1'b1, 1'b0);
    vec[8] = mk(64 * CPC,     1'b1, 8'hF0, 1'b0, 1'b1);
    vec[9] = mk(64 * CPC + 1, 1'b0, 8'h00, 1'b0, 1'b0);

    bus.start = 1'b0; bus.cont = 1'b0; bus.data_ready = 1'b0;
    #2;

    // Reset values, observed while reset is held.
    rst_n = 1'b0;
    #1;
    check("reset mux_sel", bus.mux_sel, 0);
    check("reset data_out", bus.data_out, 0);
    check("reset data_valid", bus.data_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    do_reset();

    // Single frame, table-driven checkpoints plus select on every edge.
    bus.data_ready = 1'b1;
    start_frame();
    vi = 0;
    for (int e = 0; e <= 64 * CPC + 1; e++) begin
      if (e > 0) step();
      check("t1 mux_sel", bus.mux_sel, (e >= 64 * CPC) ? 0 : e / CPC);
      if (vi < NV && vec[vi].e == e) begin
        check("t1 data_valid", bus.data_valid, vec[vi].vld);
        if (vec[vi].vld) check("t1 data_out", bus.data_out, vec[vi].dat);
        check("t1 busy", bus.busy, vec[vi].busy);
        check("t1 done", bus.done, vec[vi].done);
        bus.data_ready = vec[vi].rdy;
        vi++;
      end
    end
    check_words("t1", 1);

    // Backpressure: consumer stalls for 20 cycles after the first word.
    do_reset();
    bus.data_ready = 1'b0;
    start_frame();
    while (edge_n < 8 * CPC) step();
    check("t2 first valid", bus.data_valid, 1);
    check("t2 first data", bus.data_out, 8'h87);
    for (int i = 0; i < 20; i++) begin
      step();
      if (edge_n >= 16 * CPC) begin
        check("t2 frozen sel", bus.mux_sel, 15);
        check("t2 held data", bus.data_out, 8'h87);
        check("t2 held valid", bus.data_valid, 1);
      end
    end
    bus.data_ready = 1'b1;
    step();
    check("t2 release data", bus.data_out, 8'h96);
    check("t2 release valid", bus.data_valid, 1);
    check("t2 release sel", bus.mux_sel, 16);
    wait_done(200 * CPC);
    check("t2 done seen", bus.done, 1);
    step();
    check_words("t2", 1);

    // Continuous: wrap without done, drop cont during frame two.
    do_reset();
    bus.data_ready = 1'b1;
    bus.cont = 1'b1;
    start_frame();
    early_done = 1'b0;
    while (edge_n < 128 * CPC) begin
      step();
      if (edge_n == 96 * CPC) bus.cont = 1'b0;
      if (edge_n == 64 * CPC) begin
        check("t3 wrap sel", bus.mux_sel, 0);
        check("t3 wrap busy", bus.busy, 1);
      end
      if (edge_n < 128 * CPC && bus.done === 1'b1) early_done = 1'b1;
    end
    check("t3 no early done", early_done, 0);
    check("t3 done at end", bus.done, 1);
    check("t3 busy at end", bus.busy, 0);
    step();
    check_words("t3", 2);

    // Asynchronous reset mid-frame, then a clean restart.
    do_reset();
    bus.data_ready = 1'b1;
    start_frame();
    while (bus.mux_sel != 6'd30 && edge_n < 100 * CPC) step();
    check("t4 reached sel 30", bus.mux_sel, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4 async mux_sel", bus.mux_sel, 0);
    check("t4 async data_out", bus.data_out, 0);
    check("t4 async data_valid", bus.data_valid, 0);
    check("t4 async busy", bus.busy, 0);
    check("t4 async done", bus.done, 0);
    step();
    rst_n = 1'b1;
    step();
    got_q.delete();
    start_frame();
    while (bus.data_valid !== 1'b1 && edge_n < 20 * CPC) step();
    check("t4 restart first edge", edge_n, 8 * CPC);
    check("t4 restart first word", bus.data_out, 8'h87);
    wait_done(100 * CPC);
    step();
    check_words("t4", 1);

    // start while busy is ignored, including on the edge that ends the frame.
    do_reset();
    bus.data_ready = 1'b1;
    start_frame();
    while (bus.mux_sel != 6'd10 && edge_n < 50 * CPC) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t5 sel after start", bus.mux_sel, edge_n / CPC);
    while (edge_n < 64 * CPC - 1) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t5 done edge", bus.done, 1);
    check("t5 busy at done", bus.busy, 0);
    step();
    check("t5 stays idle", bus.busy, 0);
    check("t5 done one pulse", bus.done, 0);
    check_words("t5", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
